// File: rtl/wordle_pkg.sv
// Shared constants, cell layout and FSM state type for the Wordle row scorer.
package wordle_pkg;
    localparam logic [1:0] GREY   = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] RED    = 2'd3;

    localparam logic [4:0] LETTER_BLANK = 5'd26;
    localparam logic [4:0] LETTER_MAX   = 5'd25;
    localparam int NUM_COLS = 5;
    localparam int MAX_ROWS = 6;

    localparam int CELL_W     = 7;
    localparam int LETTER_LSB = 0;
    localparam int LETTER_W   = 5;
    localparam int COLOUR_LSB = 5;
    localparam int COLOUR_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_DONE
    } state_t;
endpackage

// File: rtl/letter_match_finder.sv
// Finds the lowest unused answer column holding the given letter.
module letter_match_finder
    import wordle_pkg::*;
(
    input  logic [4:0]  letter,
    input  logic [24:0] answer,
    input  logic [4:0]  used,
    output logic        found,
    output logic [2:0]  idx
);
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        // Scan high to low so the lowest matching column is the last write.
        for (int j = NUM_COLS - 1; j >= 0; j--) begin
            if (!used[j] && answer[5*j +: 5] == letter) begin
                found = 1'b1;
                idx   = 3'(j);
            end
        end
    end
endmodule

// File: rtl/guess_evaluator.sv
// Sequential Wordle row scorer: green pass then yellow pass, one column per clock.
// EVAL_RED_INVALID_EN: mark out-of-range letters red instead of zeroing the row.
module guess_evaluator #(
    parameter int NUM_COLS = 5,
    parameter int MAX_ROWS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        new_game,
    input  logic [34:0] guess,
    input  logic [24:0] answer,
    output logic [34:0] result,
    output logic        done,
    output logic        busy,
    output logic        invalid,
    output logic        win,
    output logic        game_over,
    output logic [2:0]  attempt
);
    import wordle_pkg::*;

    state_t                     state_q, state_d;
    logic [2:0]                 col_q, col_d;
    logic [NUM_COLS-1:0][4:0]   letters_q, letters_d;
    logic [NUM_COLS-1:0][4:0]   answer_q, answer_d;
    logic [NUM_COLS-1:0]        used_q, used_d;
    logic [NUM_COLS-1:0][1:0]   colour_q, colour_d;
    logic                       inv_q, inv_d;
    logic [34:0]                result_q, result_d;
    logic                       done_q, done_d;
    logic                       invalid_q, invalid_d;
    logic                       win_q, win_d;
    logic                       game_over_q, game_over_d;
    logic [2:0]                 attempt_q, attempt_d;

    logic                       m_found;
    logic [2:0]                 m_idx;
    logic                       all_green;
    logic [34:0]                row_result;
    logic [1:0]                 cell_colour;

    letter_match_finder u_match (
        .letter (letters_q[col_q]),
        .answer (answer_q),
        .used   (used_q),
        .found  (m_found),
        .idx    (m_idx)
    );

    always_comb begin
        all_green   = 1'b1;
        row_result  = '0;
        cell_colour = GREY;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (colour_q[c] != GREEN) all_green = 1'b0;
            cell_colour = colour_q[c];
`ifdef EVAL_RED_INVALID_EN
            if (letters_q[c] > LETTER_MAX) cell_colour = RED;
`endif
            row_result[CELL_W*c +: CELL_W] = {cell_colour, letters_q[c]};
        end
`ifndef EVAL_RED_INVALID_EN
        if (inv_q) row_result = '0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        letters_d   = letters_q;
        answer_d    = answer_q;
        used_d      = used_q;
        colour_d    = colour_q;
        inv_d       = inv_q;
        result_d    = result_q;
        done_d      = 1'b0;
        invalid_d   = invalid_q;
        win_d       = win_q;
        game_over_d = game_over_q;
        attempt_d   = attempt_q;

        if (new_game) begin
            state_d     = ST_IDLE;
            result_d    = '0;
            invalid_d   = 1'b0;
            win_d       = 1'b0;
            game_over_d = 1'b0;
            attempt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // done_q marks the trailing busy cycle; start is refused there too.
                    if (start && !done_q && !game_over_q) begin
                        for (int c = 0; c < NUM_COLS; c++)
                            letters_d[c] = guess[CELL_W*c + LETTER_LSB +: LETTER_W];
                        answer_d = answer;
                        used_d   = '0;
                        colour_d = '0;
                        inv_d    = 1'b0;
                        col_d    = '0;
                        state_d  = ST_GREEN;
                    end
                end
                ST_GREEN: begin
                    for (int c = 0; c < NUM_COLS; c++)
                        if (letters_q[c] > LETTER_MAX) inv_d = 1'b1;
                    if (letters_q[col_q] == answer_q[col_q]) begin
                        colour_d[col_q] = GREEN;
                        used_d[col_q]   = 1'b1;
                    end
                    if (col_q == 3'(NUM_COLS - 1)) begin
                        col_d   = '0;
                        state_d = ST_YELLOW;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                ST_YELLOW: begin
                    if (colour_q[col_q] != GREEN && m_found) begin
                        colour_d[col_q] = YELLOW;
                        used_d[m_idx]   = 1'b1;
                    end
                    if (col_q == 3'(NUM_COLS - 1)) state_d = ST_DONE;
                    else                           col_d   = col_q + 3'd1;
                end
                ST_DONE: begin
                    done_d    = 1'b1;
                    result_d  = row_result;
                    invalid_d = inv_q;
                    if (!inv_q) begin
                        if (attempt_q < 3'(MAX_ROWS)) attempt_d = attempt_q + 3'd1;
                        win_d       = all_green;
                        game_over_d = all_green || (attempt_d == 3'(MAX_ROWS));
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            letters_q   <= '0;
            answer_q    <= '0;
            used_q      <= '0;
            colour_q    <= '0;
            inv_q       <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
            invalid_q   <= 1'b0;
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
            attempt_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            letters_q   <= letters_d;
            answer_q    <= answer_d;
            used_q      <= used_d;
            colour_q    <= colour_d;
            inv_q       <= inv_d;
            result_q    <= result_d;
            done_q      <= done_d;
            invalid_q   <= invalid_d;
            win_q       <= win_d;
            game_over_q <= game_over_d;
            attempt_q   <= attempt_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign invalid   = invalid_q;
    assign win       = win_q;
    assign game_over = game_over_q;
    assign attempt   = attempt_q;
endmodule

// File: tb/tb_guess_evaluator.sv
// Randomized self-checking bench for guess_evaluator against a letter-count Wordle model.
module tb_guess_evaluator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        new_game = 1'b0;
    logic [34:0] guess = '0;
    logic [24:0] answer = '0;
    logic [34:0] result;
    logic        done, busy, invalid, win, game_over;
    logic [2:0]  attempt;

    guess_evaluator #(.NUM_COLS(5), .MAX_ROWS(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .new_game(new_game),
        .guess(guess), .answer(answer), .result(result), .done(done),
        .busy(busy), .invalid(invalid), .win(win), .game_over(game_over),
        .attempt(attempt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_attempt;
    bit          m_win, m_go, m_inv;
    logic [34:0] m_result;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] mk(input int l0, input int l1, input int l2, input int l3, input int l4);
        int          l[5];
        logic [34:0] r;
        l = '{l0, l1, l2, l3, l4};
        r = '0;
        for (int c = 0; c < 5; c++) r[7*c +: 7] = {2'($urandom), 5'(l[c])};
        return r;
    endfunction

    function automatic logic [24:0] mka(input int l0, input int l1, input int l2, input int l3, input int l4);
        int          l[5];
        logic [24:0] r;
        l = '{l0, l1, l2, l3, l4};
        for (int c = 0; c < 5; c++) r[5*c +: 5] = 5'(l[c]);
        return r;
    endfunction

    function automatic logic [9:0] colours(input logic [34:0] r);
        logic [9:0] v;
        for (int c = 0; c < 5; c++) v[2*c +: 2] = r[7*c + 5 +: 2];
        return v;
    endfunction

    // Classic Wordle scoring: greens first, then yellows from a pool of leftover answer letters.
    function automatic logic [34:0] score(input logic [34:0] g, input logic [24:0] a, output bit inv);
        int          cnt[32];
        int          gl[5], al[5], col[5];
        bit          bad[5];
        logic [34:0] r;
        logic [1:0]  cc;
        inv = 0;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int c = 0; c < 5; c++) begin
            gl[c]  = int'(g[7*c +: 5]);
            al[c]  = int'(a[5*c +: 5]);
            bad[c] = gl[c] > 25;
            if (bad[c]) inv = 1;
            col[c] = 0;
        end
        for (int c = 0; c < 5; c++)
            if (gl[c] == al[c]) col[c] = 2;
            else cnt[al[c]]++;
        for (int c = 0; c < 5; c++)
            if (col[c] != 2 && cnt[gl[c]] > 0) begin
                col[c] = 1;
                cnt[gl[c]]--;
            end
        r = '0;
        for (int c = 0; c < 5; c++) begin
            cc = 2'(col[c]);
`ifdef EVAL_RED_INVALID_EN
            if (bad[c]) cc = 2'd3;
`endif
            r[7*c +: 7] = {cc, 5'(gl[c])};
        end
`ifndef EVAL_RED_INVALID_EN
        if (inv) r = '0;
`endif
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_result"},  result,    m_result);
        chk({tag, "_invalid"}, invalid,   m_inv);
        chk({tag, "_win"},     win,       m_win);
        chk({tag, "_go"},      game_over, m_go);
        chk({tag, "_attempt"}, attempt,   m_attempt);
    endtask

    task automatic run_row(input string tag, input logic [34:0] g, input logic [24:0] a);
        bit          inv;
        bit          ag;
        logic [34:0] exp;
        int          n;
        exp = score(g, a, inv);
        guess = g; answer = a; start = 1'b1;
        tick();
        start = 1'b0;
        guess = 35'({$urandom, $urandom});
        answer = 25'($urandom);
        chk({tag, "_busy_rise"}, busy, 1'b1);
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 11);
        m_result = exp;
        m_inv = inv;
        if (!inv) begin
            ag = 1;
            for (int c = 0; c < 5; c++) if (exp[7*c + 5 +: 2] != 2'd2) ag = 0;
            if (m_attempt < 6) m_attempt++;
            m_win = ag;
            m_go  = ag || (m_attempt == 6);
        end
        check_outputs(tag);
        chk({tag, "_busy_done"}, busy, 1'b1);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        check_outputs({tag, "_hold"});
    endtask

    task automatic do_new_game(input string tag);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_attempt = 0; m_win = 0; m_go = 0; m_inv = 0; m_result = '0;
        check_outputs(tag);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int          dones;
        int          busies;
        int          al[5], gl[5];
        logic [34:0] g;
        logic [24:0] a;

        m_attempt = 0; m_win = 0; m_go = 0; m_inv = 0; m_result = '0;
        #12;
        check_outputs("reset");
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // CRANE / CRANE
        run_row("crane", mk(2, 17, 0, 13, 4), mka(2, 17, 0, 13, 4));
        chk("crane_col", colours(result), 10'h2AA);
        chk("crane_win", win, 1'b1);
        do_new_game("ng1");

        // ABBEY answer, BOBBY guess
        run_row("abbey", mk(1, 14, 1, 1, 24), mka(0, 1, 1, 4, 24));
        chk("abbey_col", colours(result), 10'h221);

        // Blank in column 3
        run_row("blank", mk(2, 17, 0, 26, 4), mka(2, 17, 0, 13, 4));
        chk("blank_inv", invalid, 1'b1);
        chk("blank_att", attempt, 3'd1);
`ifdef EVAL_RED_INVALID_EN
        chk("blank_col", colours(result), 10'h2EA);
`else
        chk("blank_zero", result, 35'd0);
`endif
        do_new_game("ng2");

        // Six misses end the game; a seventh start is ignored
        for (int i = 0; i < 6; i++)
            run_row($sformatf("miss%0d", i), mk(1, 20, 8, 11, 19), mka(2, 17, 0, 13, 4));
        chk("six_go", game_over, 1'b1);
        chk("six_win", win, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        busies = 0; dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) busies++;
            if (done) dones++;
            tick();
        end
        chk("seventh_busy", busies, 0);
        chk("seventh_done", dones, 0);
        check_outputs("seventh");
        do_new_game("ng3");

        // start while busy is dropped
        guess = mk(2, 17, 0, 13, 4); answer = mka(2, 17, 0, 13, 4); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        guess = mk(1, 14, 1, 1, 24); answer = mka(0, 1, 1, 4, 24); start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dones++;
            tick();
        end
        chk("busy_start_dones", dones, 1);
        m_result = score(mk(2, 17, 0, 13, 4), mka(2, 17, 0, 13, 4), m_inv);
        chk("busy_start_res", colours(result), 10'h2AA);
        chk("busy_start_att", attempt, 3'd1);
        do_new_game("ng4");

        // Reset mid-scoring
        run_row("pre_rst", mk(0, 1, 2, 3, 4), mka(4, 3, 2, 1, 0));
        guess = mk(2, 17, 0, 13, 4); answer = mka(2, 17, 0, 13, 4); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        m_attempt = 0; m_win = 0; m_go = 0; m_inv = 0; m_result = '0;
        check_outputs("rst_mid");
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            tick();
        end
        chk("rst_no_done", dones, 0);

        // new_game beats start
        new_game = 1'b1; start = 1'b1;
        tick();
        new_game = 1'b0; start = 1'b0;
        busies = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy || done) busies++;
            tick();
        end
        chk("ng_start_busy", busies, 0);
        check_outputs("ng_start");

        // Randomized rows
        for (int r = 0; r < 40; r++) begin
            if (m_go) do_new_game($sformatf("rng%0d", r));
            for (int c = 0; c < 5; c++) al[c] = int'($urandom_range(0, 25));
            for (int c = 0; c < 5; c++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: gl[c] = al[$urandom_range(0, 4)];
                    9:             gl[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(26, 31)) : al[c];
                    default:       gl[c] = int'($urandom_range(0, 25));
                endcase
            end
            if ($urandom_range(0, 9) == 0) gl = al;
            g = mk(gl[0], gl[1], gl[2], gl[3], gl[4]);
            a = mka(al[0], al[1], al[2], al[3], al[4]);
            run_row($sformatf("rand%0d", r), g, a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
